// File: rtl/lvt_write_scheduler.sv
// lvt_write_scheduler: live-value-table write scheduler that spreads writes across r BRAM banks
// and reports which bank holds the newest copy of each address.
module lvt_write_scheduler #(
    parameter int index_width = 4,
    parameter int r           = 4,
    parameter int n_bits_r    = 2,
    parameter int n_req       = 2,
    parameter int data_width  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [n_req-1:0]            req_valid,
    output logic [n_req-1:0]            req_ready,
    input  logic [n_req*index_width-1:0] req_addr,
    input  logic [n_req*data_width-1:0] req_data,
    output logic [r-1:0]                bank_we,
    output logic [index_width-1:0]      bank_addr,
    output logic [data_width-1:0]       bank_data,
    input  logic [index_width-1:0]      rd_addr,
    output logic [n_bits_r-1:0]         rd_bank,
    output logic                        rd_hit,
    output logic                        init_done
);
    localparam int depth = 2 ** index_width;
    localparam int rw    = (n_req > 1) ? $clog2(n_req) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [index_width-1:0]  r_init_ptr;
    logic [rw-1:0]           r_rr_ptr, w_gnt_idx;
    logic                    w_any, w_accept;
    logic [n_bits_r-1:0]     r_count [depth];
    logic [depth-1:0]        r_written;
    logic [index_width-1:0]  w_addr;
    logic [data_width-1:0]   w_data;
    logic [n_bits_r-1:0]     w_bank, w_bank_nxt, w_rd_count;
    logic [r-1:0]            r_bank_we;
    logic [index_width-1:0]  r_bank_addr;
    logic [data_width-1:0]   r_bank_data;
    logic [n_bits_r-1:0]     r_rd_bank;
    logic                    r_rd_hit;

    // requester index p+k folded back into 0..n_req-1
    function automatic logic [rw-1:0] wrap_idx(input logic [rw-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return rw'((s >= n_req) ? s - n_req : s);
    endfunction

    // round-robin search starting at rr_ptr; first valid requester wins
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < n_req; k++) begin
            if (!w_any && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_any     = 1'b1;
                w_gnt_idx = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // a flush cycle swallows any request so nothing lands in a table about to be cleared
    assign w_accept   = w_any && (r_state == RUN) && !flush;
    assign req_ready  = w_accept ? (n_req'(1) << w_gnt_idx) : '0;
    assign w_addr     = req_addr[w_gnt_idx*index_width +: index_width];
    assign w_data     = req_data[w_gnt_idx*data_width +: data_width];
    assign w_bank     = r_count[w_addr];
    assign w_bank_nxt = (w_bank == n_bits_r'(r - 1)) ? '0 : w_bank + n_bits_r'(1);
    assign w_rd_count = r_count[rd_addr];

    // next state: sweep ends after the last entry, flush always sends us back to the sweep start
    always_comb begin
        w_state_nxt = (r_state == INIT) ? ((!flush && (&r_init_ptr)) ? RUN : INIT)
                                        : (flush ? INIT : RUN);
    end

    // state, sweep pointer, arbitration pointer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= INIT;
            r_init_ptr  <= '0;
            r_rr_ptr    <= '0;
            r_bank_we   <= '0;
            r_bank_addr <= '0;
            r_bank_data <= '0;
            r_rd_bank   <= '0;
            r_rd_hit    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_ptr  <= (r_state == INIT && !flush) ? r_init_ptr + index_width'(1) : '0;
            r_rr_ptr    <= w_accept ? wrap_idx(w_gnt_idx, 1) : r_rr_ptr;
            r_bank_we   <= w_accept ? (r'(1) << w_bank) : '0;
            r_bank_addr <= w_accept ? w_addr : r_bank_addr;
            r_bank_data <= w_accept ? w_data : r_bank_data;
            r_rd_hit    <= (r_state == RUN) && r_written[rd_addr];
            r_rd_bank   <= (r_state != RUN) ? '0 :
                           (w_rd_count == '0) ? n_bits_r'(r - 1) : w_rd_count - n_bits_r'(1);
        end
    end

    // live-value table: cleared by the sweep, bumped on every accepted write
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_count[r_init_ptr]   <= '0;
            r_written[r_init_ptr] <= 1'b0;
        end else if (w_accept) begin
            r_count[w_addr]   <= w_bank_nxt;
            r_written[w_addr] <= 1'b1;
        end
    end

    assign bank_we   = r_bank_we;
    assign bank_addr = r_bank_addr;
    assign bank_data = r_bank_data;
    assign rd_bank   = r_rd_bank;
    assign rd_hit    = r_rd_hit;
    assign init_done = (r_state == RUN);
endmodule

// File: tb/tb_lvt_write_scheduler.sv
// tb_lvt_write_scheduler: scoreboard bench with a per-address write-count reference model
module tb_lvt_write_scheduler;
    localparam int IW = 4, R = 4, NB = 2, N = 2, DW = 8, D = 16;

    logic              clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready;
    logic [N*IW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [R-1:0]      bank_we;
    logic [IW-1:0]     bank_addr, rd_addr = '0;
    logic [DW-1:0]     bank_data;
    logic [NB-1:0]     rd_bank;
    logic              rd_hit, init_done;

    typedef struct {int we; int addr; int data;} wr_t;
    typedef struct {int hit; int bank;} rd_t;

    int  checks = 0, errors = 0;
    int  nw [D];
    int  rr = 0;
    bit  mon_on = 1'b0;
    wr_t wq[$];
    rd_t rq[$];

    lvt_write_scheduler #(.index_width(IW), .r(R), .n_bits_r(NB), .n_req(N), .data_width(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_data(bank_data), .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_hit(rd_hit),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        foreach (nw[i]) nw[i] = 0;
    endtask

    // called at the negedge right after the edge that (re)started the sweep
    task automatic sweep();
        flush     = 1'b0;
        req_valid = '1;
        for (int k = 1; k <= D; k++) begin
            @(negedge clk);
            chk("init_done", int'(init_done), int'(k == D));
            if (k < D) chk("init_ready", int'(req_ready), 0);
            if (k > 1 && k < D) chk("init_rd_hit", int'(rd_hit), 0);
        end
        req_valid = '0;
    endtask

    // asynchronous reset pulse in the middle of a cycle, then a full sweep
    task automatic reset_pulse();
        #2;
        reset  = 1'b0;
        mon_on = 1'b1;
        wq.delete();
        rq.delete();
        model_clear();
        rr = 0;
        #1;
        chk("rst_bank_we", int'(bank_we), 0);
        chk("rst_bank_addr", int'(bank_addr), 0);
        chk("rst_bank_data", int'(bank_data), 0);
        chk("rst_rd_bank", int'(rd_bank), 0);
        chk("rst_rd_hit", int'(rd_hit), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        sweep();
    endtask

    // one RUN cycle: drive at negedge, predict, push expectations, advance to next negedge
    task automatic step(input logic [N-1:0] v, input logic [N*IW-1:0] a,
                        input logic [N*DW-1:0] d, input logic [IW-1:0] ra, input logic fl);
        int  g, ad;
        wr_t w;
        rd_t e;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        rd_addr   = ra;
        flush     = fl;
        #1;
        g = -1;
        if (!fl)
            for (int k = 0; k < N; k++)
                if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
        chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
        e.hit  = int'(nw[ra] > 0);
        e.bank = (nw[ra] + R - 1) % R;
        rq.push_back(e);
        if (g >= 0) begin
            ad     = int'(a[g*IW +: IW]);
            w.we   = 1 << (nw[ad] % R);
            w.addr = ad;
            w.data = int'(d[g*DW +: DW]);
            wq.push_back(w);
            nw[ad]++;
            rr = (g + 1) % N;
        end
        if (fl) model_clear();
        @(negedge clk);
    endtask

    // monitor: registered outputs are compared just after every rising edge
    initial begin
        wr_t we_e;
        rd_t rd_e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (wq.size() > 0) begin
                    we_e = wq.pop_front();
                    chk("bank_we", int'(bank_we), we_e.we);
                    chk("bank_addr", int'(bank_addr), we_e.addr);
                    chk("bank_data", int'(bank_data), we_e.data);
                end else begin
                    chk("bank_we_idle", int'(bank_we), 0);
                end
                if (rq.size() > 0) begin
                    rd_e = rq.pop_front();
                    chk("rd_hit", int'(rd_hit), rd_e.hit);
                    chk("rd_bank", int'(rd_bank), rd_e.bank);
                end
            end
        end
    end

    initial begin
        logic fl;
        model_clear();
        @(negedge clk);
        reset_pulse();
        // same address back to back walks banks 0,1,2,3 then wraps
        repeat (5) step(2'b01, {4'd0, 4'd5}, {8'd0, 8'($urandom)}, 4'd5, 1'b0);
        // both requesters always valid: grants alternate
        repeat (6) step(2'b11, {4'd8, 4'd7}, 16'($urandom), 4'd7, 1'b0);
        // two writes to 3, then lookups of 3 and 4
        repeat (2) step(2'b01, {4'd0, 4'd3}, 16'($urandom), 4'd0, 1'b0);
        step(2'b00, '0, '0, 4'd3, 1'b0);
        step(2'b00, '0, '0, 4'd4, 1'b0);
        // flush clears the table; next write to 3 uses bank 0
        step(2'b11, {4'd3, 4'd3}, 16'($urandom), 4'd3, 1'b1);
        sweep();
        step(2'b00, '0, '0, 4'd3, 1'b0);
        step(2'b10, {4'd3, 4'd0}, 16'($urandom), 4'd3, 1'b0);
        step(2'b00, '0, '0, 4'd3, 1'b0);
        // randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 49) == 0);
            step(N'($urandom), (N*IW)'($urandom), (N*DW)'($urandom), IW'($urandom), fl);
            if (fl) sweep();
        end
        // reset in the middle of a sweep
        step(2'b01, {4'd0, 4'd9}, 16'($urandom), 4'd9, 1'b1);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        reset_pulse();
        // reset in the middle of an accept
        repeat (3) step(2'b01, {4'd0, 4'd9}, 16'($urandom), 4'd9, 1'b0);
        req_valid = 2'b11;
        req_addr  = {4'd9, 4'd9};
        reset_pulse();
        step(2'b00, '0, '0, 4'd9, 1'b0);
        repeat (3) step(2'b11, {4'd9, 4'd9}, 16'($urandom), 4'd9, 1'b0);
        step(2'b00, '0, '0, 4'd9, 1'b0);
        repeat (2) @(negedge clk);
        chk("wq_drain", wq.size(), 0);
        chk("rq_drain", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
